// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-setpoint path and the PWM comparator stage.
package pwm_pkg;

  localparam int CBITS_DEF = 15;

  typedef enum logic [2:0] {
    ST_MANUAL   = 3'd0,
    ST_UP       = 3'd1,
    ST_HOLD_TOP = 3'd2,
    ST_DOWN     = 3'd3,
    ST_HOLD_BOT = 3'd4
  } ramp_state_e;

  // Duty code lands in the top dw bits of the cbits-wide compare threshold.
  function automatic logic [31:0] duty_to_cmp(input logic [31:0] duty,
                                              input int dw,
                                              input int cbits);
    return duty << (cbits - dw);
  endfunction

endpackage

// File: rtl/pwm_period_ctr.sv
// Free-running PWM period time base; the PWM stage instantiates the same block
// so duty updates and compare periods stay aligned.
module pwm_period_ctr
  import pwm_pkg::*;
#(
  parameter int CBITS = CBITS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic boundary_o,
  output logic period_start_o
);

  logic [CBITS-1:0] count_q;
  logic [CBITS-1:0] count_d;
  logic             period_start_q;

  assign count_d        = count_q + CBITS'(1);
  assign boundary_o     = &count_q;
  assign period_start_o = period_start_q;

  // period_start is the registered boundary, so it is high while the count reads 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_start_q <= boundary_o;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-code source for the PWM stage: manual pass-through or a breathing ramp,
// with all updates taken only at PWM period boundaries.
//
// state       | meaning
// ST_MANUAL   | duty follows manual_duty_i at each boundary
// ST_UP       | duty +1 every STEP_PERIODS boundaries until DMAX
// ST_HOLD_TOP | dwell at DMAX for HOLD_PERIODS boundaries
// ST_DOWN     | duty -1 every STEP_PERIODS boundaries until 0
// ST_HOLD_BOT | dwell at 0 for HOLD_PERIODS boundaries
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int CBITS        = CBITS_DEF,
  parameter int DW           = 3,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          mode_ramp_i,
  input  logic [DW-1:0] manual_duty_i,
  output logic [DW-1:0] duty_o,
  output logic          period_start_o,
  output logic          ramp_dir_o
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_PERIODS - 1);
  localparam logic [DW-1:0] DMAX      = {DW{1'b1}};

  ramp_state_e   state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic          dir_q, dir_d;
  logic [SW-1:0] step_q, step_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          boundary;

  pwm_period_ctr #(.CBITS(CBITS)) u_period_ctr (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .boundary_o     (boundary),
    .period_start_o (period_start_o)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    step_d  = step_q;
    hold_d  = hold_q;
    if (boundary && en_i) begin
      if (state_q == ST_MANUAL) begin
        if (mode_ramp_i) begin
          state_d = (duty_q == DMAX) ? ST_HOLD_TOP : ST_UP;
          dir_d   = 1'b1;
          step_d  = '0;
          hold_d  = '0;
        end else begin
          duty_d = manual_duty_i;
        end
      end else if (!mode_ramp_i) begin
        // Leaving the ramp loads the manual code on the same boundary.
        state_d = ST_MANUAL;
        duty_d  = manual_duty_i;
        step_d  = '0;
        hold_d  = '0;
      end else begin
        unique case (state_q)
          ST_UP: begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (duty_q != DMAX) duty_d = duty_q + DW'(1);
              if (duty_d == DMAX) state_d = ST_HOLD_TOP;
            end else begin
              step_d = step_q + SW'(1);
            end
          end
          ST_HOLD_TOP: begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              state_d = ST_DOWN;
              dir_d   = 1'b0;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          ST_DOWN: begin
            if (step_q == STEP_LAST) begin
              step_d = '0;
              if (duty_q != '0) duty_d = duty_q - DW'(1);
              if (duty_d == '0) state_d = ST_HOLD_BOT;
            end else begin
              step_d = step_q + SW'(1);
            end
          end
          ST_HOLD_BOT: begin
            if (hold_q == HOLD_LAST) begin
              hold_d  = '0;
              state_d = ST_UP;
              dir_d   = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          default: state_d = ST_MANUAL;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_MANUAL;
      duty_q  <= '0;
      dir_q   <= 1'b1;
      step_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
    end
  end

  assign duty_o     = duty_q;
  assign ramp_dir_o = dir_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed timeline with literal pins, then random stimulus
// against a period-level reference model checked every cycle.
module tb_pwm_duty_ramp;

  localparam int CBITS = 4;
  localparam int DW    = 3;
  localparam int STEP  = 2;
  localparam int HOLD  = 3;
  localparam int PER   = 1 << CBITS;
  localparam int DMAX  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] man = '0;
  logic [DW-1:0] duty;
  logic          ps;
  logic          dir;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: position in period plus ramp phase described as
  // (in ramp, rising, dwelling, boundaries spent in this phase).
  int m_pc, m_duty, m_cnt;
  bit m_ps, m_dir, m_ramp, m_rise, m_hold;

  always #5 clk = ~clk;

  pwm_duty_ramp #(
    .CBITS(CBITS), .DW(DW), .STEP_PERIODS(STEP), .HOLD_PERIODS(HOLD)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .mode_ramp_i    (mode),
    .manual_duty_i  (man),
    .duty_o         (duty),
    .period_start_o (ps),
    .ramp_dir_o     (dir)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ps = 0; m_duty = 0; m_cnt = 0;
    m_dir = 1; m_ramp = 0; m_rise = 1; m_hold = 0;
  endtask

  task automatic model_boundary();
    if (!m_ramp) begin
      if (mode) begin
        m_ramp = 1; m_dir = 1; m_rise = 1; m_cnt = 0;
        m_hold = (m_duty == DMAX);
      end else begin
        m_duty = int'(man);
      end
    end else if (!mode) begin
      m_ramp = 0; m_duty = int'(man); m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_hold) begin
        if (m_cnt == HOLD) begin
          m_cnt = 0; m_hold = 0; m_rise = !m_rise; m_dir = m_rise;
        end
      end else if (m_cnt == STEP) begin
        m_cnt = 0;
        m_duty = m_rise ? m_duty + 1 : m_duty - 1;
        if (m_duty == (m_rise ? DMAX : 0)) m_hold = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        model_reset();
        cyc = 0;
      end else begin
        cyc++;
        if (m_pc == PER - 1 && en) model_boundary();
        m_ps = (m_pc == PER - 1);
        m_pc = (m_pc + 1) % PER;
      end
      #1;
      chk("duty", int'(duty), m_duty);
      chk("period_start", int'(ps), int'(m_ps));
      chk("ramp_dir", int'(dir), int'(m_dir));
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_cycle", cyc, n);
  endtask

  // Literal pin: checks the DUT and the model against a hand-computed value.
  task automatic lit(input string name, input int act, input int mdl, input int exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  initial begin
    rst = 1; en = 1; mode = 0; man = 3'd5;
    repeat (2) @(negedge clk);
    rst = 0;

    wait_cyc(15);  lit("pre_first_duty", int'(duty), m_duty, 0);
                   lit("pre_first_ps", int'(ps), int'(m_ps), 0);
    wait_cyc(16);  lit("first_duty", int'(duty), m_duty, 5);
                   lit("first_ps", int'(ps), int'(m_ps), 1);
    wait_cyc(32);  lit("second_ps", int'(ps), int'(m_ps), 1);

    wait_cyc(33);  man = 3'd0;
    wait_cyc(49);  mode = 1;
    wait_cyc(96);  lit("up_1", int'(duty), m_duty, 1);
    wait_cyc(287); lit("up_6", int'(duty), m_duty, 6);
    wait_cyc(288); lit("top_7", int'(duty), m_duty, 7);
                   lit("top_dir", int'(dir), int'(m_dir), 1);
    wait_cyc(335); lit("hold_end_dir", int'(dir), int'(m_dir), 1);
    wait_cyc(336); lit("down_enter_duty", int'(duty), m_duty, 7);
                   lit("down_enter_dir", int'(dir), int'(m_dir), 0);
    wait_cyc(368); lit("down_6", int'(duty), m_duty, 6);
    wait_cyc(560); lit("bot_0", int'(duty), m_duty, 0);
    wait_cyc(607); lit("bot_dir", int'(dir), int'(m_dir), 0);
    wait_cyc(608); lit("rise_again_dir", int'(dir), int'(m_dir), 1);
    wait_cyc(640); lit("rise_again_1", int'(duty), m_duty, 1);
    wait_cyc(736); lit("up_4", int'(duty), m_duty, 4);

    wait_cyc(740); mode = 0; man = 3'd2;
    wait_cyc(751); lit("exit_pre", int'(duty), m_duty, 4);
    wait_cyc(752); lit("exit_manual", int'(duty), m_duty, 2);

    wait_cyc(753); man = 3'd7;
    wait_cyc(768); lit("manual_7", int'(duty), m_duty, 7);
    wait_cyc(770); mode = 1;
    wait_cyc(831); lit("direct_hold_dir", int'(dir), int'(m_dir), 1);
    wait_cyc(832); lit("direct_hold_end", int'(duty), m_duty, 7);
                   lit("direct_hold_dir0", int'(dir), int'(m_dir), 0);
    wait_cyc(864); lit("direct_down_6", int'(duty), m_duty, 6);

    wait_cyc(960); lit("down_3", int'(duty), m_duty, 3);
    wait_cyc(962); en = 0;
    wait_cyc(1040); lit("frozen_duty", int'(duty), m_duty, 3);
                    lit("frozen_ps", int'(ps), int'(m_ps), 1);
    wait_cyc(1042); en = 1;
    wait_cyc(1071); lit("resume_pre", int'(duty), m_duty, 3);
    wait_cyc(1072); lit("resume_2", int'(duty), m_duty, 2);

    wait_cyc(1080); rst = 1; mode = 0; man = 3'd3;
    @(negedge clk);
    lit("rst_duty", int'(duty), m_duty, 0);
    lit("rst_dir", int'(dir), int'(m_dir), 1);
    lit("rst_ps", int'(ps), int'(m_ps), 0);
    rst = 0;
    wait_cyc(15);  lit("rst_pre_ps", int'(ps), int'(m_ps), 0);
    wait_cyc(16);  lit("rst_first_ps", int'(ps), int'(m_ps), 1);
                   lit("rst_first_duty", int'(duty), m_duty, 3);

    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 599) == 0) mode = ~mode;
      if ($urandom_range(0, 79) == 0) man = DW'($urandom_range(0, DMAX));
      en = ($urandom_range(0, 9) != 0);
      if (i == 100) mode = 1;
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
